// File: rtl/i2s_rx_controller.sv
// i2s_rx_controller
//   Master-side I2S receive sequencer for a microphone front end. Divides
//   clk_in down to the bit clock, generates word select, runs a number of
//   discarded warm-up frames, then deserializes the top 16 bits of every
//   left slot and hands them downstream over a valid/ready handshake.
//
// Ports
//   clk_in           system clock (single domain)
//   rst_in           asynchronous active-high reset
//   enable_in        level; rising edge starts, low stops after current frame
//   mic_data_in      serial microphone data (synchronized internally)
//   sck_out          I2S bit clock, CLK_DIV clk_in cycles per half period
//   ws_out           word select, 0 = left slot, 1 = right slot
//   sample_out       signed 16-bit sample (top bits of the left slot)
//   sample_valid_out sample available, held until accepted
//   sample_ready_in  consumer ready
//   overrun_out      sticky: an unaccepted sample was overwritten
//   busy_out         block is not idle
module i2s_rx_controller #(
    parameter int CLK_DIV       = 16,
    parameter int WARMUP_FRAMES = 4096
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               enable_in,
    input  logic               mic_data_in,
    output logic               sck_out,
    output logic               ws_out,
    output logic signed [15:0] sample_out,
    output logic               sample_valid_out,
    input  logic               sample_ready_in,
    output logic               overrun_out,
    output logic               busy_out
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int FRM_W = $clog2(WARMUP_FRAMES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [FRM_W-1:0] WARM_LAST = FRM_W'(WARMUP_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, WARMUP, RUN, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [5:0]          bit_cnt_q, bit_cnt_d;
    logic [FRM_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic                sck_q, sck_d;
    logic                ws_q, ws_d;
    logic                enable_q;
    logic                mic_sync_p0, mic_sync_p1;
    logic [15:0]         shift_q, shift_d;
    logic                cap_done_q, cap_done_d;
    logic signed [15:0]  sample_q, sample_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;

    logic                tick, sck_rise, sck_fall, frame_end, en_rise;
    logic [5:0]          bit_inc;

    assign tick      = (state_q != IDLE) && (div_cnt_q == DIV_LAST);
    assign sck_rise  = tick && !sck_q;
    assign sck_fall  = tick && sck_q;
    assign frame_end = sck_fall && (bit_cnt_q == 6'd63);
    assign en_rise   = enable_in && !enable_q;
    assign bit_inc   = bit_cnt_q + 6'd1;

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        frame_cnt_d = frame_cnt_q;
        sck_d       = sck_q;
        ws_d        = ws_q;
        shift_d     = shift_q;
        cap_done_d  = 1'b0;
        sample_d    = sample_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;

        // Stage: bit clock and frame timing
        if (state_q == IDLE) begin
            div_cnt_d   = '0;
            bit_cnt_d   = '0;
            frame_cnt_d = '0;
            sck_d       = 1'b0;
            ws_d        = 1'b0;
        end else if (tick) begin
            div_cnt_d = '0;
            sck_d     = ~sck_q;
            if (sck_q) begin
                bit_cnt_d = bit_inc;
                // ws follows the new bit count so it flips one bit ahead of
                // the slot MSB, matching the I2S one-bit delay.
                ws_d      = bit_inc[5];
            end
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        // Stage: capture, slot bits 1..16 only (bit 0 is the I2S delay)
        if (state_q == RUN && sck_rise && bit_cnt_q >= 6'd1 && bit_cnt_q <= 6'd16) begin
            shift_d    = {shift_q[14:0], mic_sync_p1};
            cap_done_d = (bit_cnt_q == 6'd16);
        end

        // Stage: delivery; a completing sample beats a same-cycle accept
        if (valid_q && sample_ready_in) begin
            valid_d = 1'b0;
        end
        if (cap_done_q) begin
            sample_d = $signed(shift_q);
            valid_d  = 1'b1;
            if (valid_q && !sample_ready_in) begin
                overrun_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (en_rise) begin
                    state_d   = WARMUP;
                    overrun_d = 1'b0;
                end
            end
            WARMUP: begin
                if (!enable_in) begin
                    state_d = DRAIN;
                end else if (frame_end) begin
                    if (frame_cnt_q == WARM_LAST) begin
                        state_d = RUN;
                    end else begin
                        frame_cnt_d = frame_cnt_q + FRM_W'(1);
                    end
                end
            end
            RUN: begin
                if (!enable_in) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (frame_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            frame_cnt_q <= '0;
            sck_q       <= 1'b0;
            ws_q        <= 1'b0;
            enable_q    <= 1'b0;
            mic_sync_p0 <= 1'b0;
            mic_sync_p1 <= 1'b0;
            cap_done_q  <= 1'b0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            sck_q       <= sck_d;
            ws_q        <= ws_d;
            enable_q    <= enable_in;
            mic_sync_p0 <= mic_data_in;
            mic_sync_p1 <= mic_sync_p0;
            cap_done_q  <= cap_done_d;
            sample_q    <= sample_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    // Deserializer contents are only meaningful once 16 bits have shifted in.
    always_ff @(posedge clk_in) begin
        shift_q <= shift_d;
    end

    assign sck_out          = sck_q;
    assign ws_out           = ws_q;
    assign sample_out       = sample_q;
    assign sample_valid_out = valid_q;
    assign overrun_out      = overrun_q;
    assign busy_out         = (state_q != IDLE);

endmodule

// File: tb/tb_i2s_rx_controller.sv
module tb_i2s_rx_controller;

    localparam int CLK_DIV = 2;
    localparam int W       = 2;
    localparam int NV      = 7;
    localparam logic [31:0] RIGHT = 32'hFFFF_FFFF;
    // enable-registering edge -> first valid: first sck rise, then 64*W+16
    // bit periods, then one cycle of delivery latency
    localparam int FIRST_VALID = CLK_DIV + 2 * CLK_DIV * (64 * W + 16) + 1;
    localparam int FRAME_CYC   = 128 * CLK_DIV;

    logic clk = 1'b0;
    logic rst, enable, mic_data, ready;
    logic sck, ws, valid, overrun, busy;
    logic signed [15:0] sample;

    i2s_rx_controller #(.CLK_DIV(CLK_DIV), .WARMUP_FRAMES(W)) dut (
        .clk_in(clk), .rst_in(rst), .enable_in(enable), .mic_data_in(mic_data),
        .sck_out(sck), .ws_out(ws), .sample_out(sample),
        .sample_valid_out(valid), .sample_ready_in(ready),
        .overrun_out(overrun), .busy_out(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] left;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs [NV];

    int checks = 0, failures = 0;
    int cyc = 0;
    logic [31:0] lw [16];
    logic [15:0] ex [16];
    int nexp = 0;
    bit sb_on = 1'b0;
    logic [15:0] exp_q [$];
    logic [15:0] got_q [$];

    int rcnt = 0, en_cyc = 0, valid_cycles = 0;
    int first_rise = -1, second_rise = -1, ws_hi = -1, ws_lo = -1;
    int first_valid = -1, busy_fall = -1;
    logic prev_sck = 1'b0, prev_ws = 1'b0, prev_valid = 1'b0, prev_busy = 1'b0;
    int g, f, n, fi;
    logic [63:0] frame64;

    always @(posedge clk) cyc <= cyc + 1;

    // Microphone model and output monitor. Data for the next bit is presented
    // right after the receiver has sampled the current one.
    initial mic_data = 1'b0;
    always @(negedge clk) begin
        if (!busy) begin
            rcnt     = 0;
            mic_data = 1'b0;
        end else if (sck && !prev_sck) begin
            g  = rcnt + 1;
            f  = g / 64;
            n  = g % 64;
            fi = (f > 15) ? 15 : f;
            frame64  = {lw[fi], RIGHT};
            mic_data = frame64[(64 - n) % 64];
            if (n == 1 && sb_on && f >= W && f - W < nexp && f < 16)
                exp_q.push_back(ex[f]);
            if (rcnt == 0) first_rise = cyc;
            if (rcnt == 1) second_rise = cyc;
            rcnt = rcnt + 1;
        end
        if (ws && !prev_ws && ws_hi < 0) ws_hi = cyc;
        if (!ws && prev_ws && ws_lo < 0) ws_lo = cyc;
        if (valid && !prev_valid && first_valid < 0) first_valid = cyc;
        if (!busy && prev_busy && busy_fall < 0) busy_fall = cyc;
        if (sb_on && valid) valid_cycles = valid_cycles + 1;
        if (sb_on && valid && ready) got_q.push_back(sample);
        prev_sck   = sck;
        prev_ws    = ws;
        prev_valid = valid;
        prev_busy  = busy;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_run();
        step();
        first_rise  = -1; second_rise = -1; ws_hi = -1; ws_lo = -1;
        first_valid = -1; busy_fall = -1;
        enable = 1'b1;
        en_cyc = cyc + 1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sck"}, {31'd0, sck}, 32'd0);
        check({tag, "_ws"}, {31'd0, ws}, 32'd0);
        check({tag, "_sample"}, {16'd0, sample}, 32'd0);
        check({tag, "_valid"}, {31'd0, valid}, 32'd0);
        check({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    logic [15:0] got_v, exp_v;
    bit quiet;

    initial begin
        vecs[0] = '{left: 32'h8001_2300, exp: 16'h8001};
        vecs[1] = '{left: 32'h7FFF_FFFF, exp: 16'h7FFF};
        vecs[2] = '{left: 32'h0000_0000, exp: 16'h0000};
        vecs[3] = '{left: 32'hFFFF_0000, exp: 16'hFFFF};
        vecs[4] = '{left: 32'h1234_5678, exp: 16'h1234};
        vecs[5] = '{left: 32'h0001_FFFF, exp: 16'h0001};
        vecs[6] = '{left: 32'hA5A5_5A5A, exp: 16'hA5A5};
        for (int i = 0; i < 16; i++) begin
            lw[i] = 32'h0F0F_0F0F;
            ex[i] = 16'h0;
        end

        rst = 1'b1; enable = 1'b0; ready = 1'b1;
        repeat (3) step();
        check_all_zero("reset_held");
        rst = 1'b0;
        repeat (3) step();
        check_all_zero("reset_released");

        // Run 1: warm-up timing, table-driven capture, drain
        lw[0] = 32'h5A5A_0000;
        lw[1] = 32'h3C3C_0000;
        for (int i = 0; i < NV; i++) begin
            lw[W + i] = vecs[i].left;
            ex[W + i] = vecs[i].exp;
        end
        nexp  = NV;
        sb_on = 1'b1;
        start_run();
        for (int i = 0; i < NV; i++) begin
            for (int t = 0; t < 1000 && got_q.size() == 0; t++) step();
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                checks = checks + 1;
                failures = failures + 1;
                $display("FAIL vec%0d: got %0d samples expected 1 (queued %0d)", i, got_q.size(), exp_q.size());
            end else begin
                got_v = got_q.pop_front();
                exp_v = exp_q.pop_front();
                check($sformatf("vec%0d", i), {16'd0, got_v}, {16'd0, exp_v});
            end
        end
        check("first_sck_rise", first_rise - en_cyc, CLK_DIV);
        check("sck_period", second_rise - first_rise, 2 * CLK_DIV);
        check("ws_low_span", ws_hi - en_cyc, 64 * CLK_DIV);
        check("ws_high_span", ws_lo - ws_hi, 64 * CLK_DIV);
        check("first_valid_latency", first_valid - en_cyc, FIRST_VALID);

        for (int t = 0; t < 3000 && rcnt < 64 * (W + NV) + 11; t++) step();
        enable = 1'b0;
        for (int t = 0; t < 1000 && busy; t++) step();
        check("drain_idle_cycle", busy_fall - en_cyc, FRAME_CYC * (W + NV + 1));
        check("drain_busy", {31'd0, busy}, 32'd0);
        check("drain_sck", {31'd0, sck}, 32'd0);
        check("drain_ws", {31'd0, ws}, 32'd0);
        check("drain_no_sample", got_q.size() + exp_q.size(), 0);
        check("valid_cycles", valid_cycles, NV);
        sb_on = 1'b0;

        // Run 2: backpressure and overrun
        lw[0] = 32'hDEAD_BEEF; lw[1] = 32'hDEAD_BEEF;
        lw[2] = 32'h1234_ABCD; lw[3] = 32'h5678_0F0F;
        ready = 1'b0;
        start_run();
        for (int t = 0; t < 1000 && !valid; t++) step();
        check("bp_first_sample", {16'd0, sample}, 32'h1234);
        check("bp_no_overrun_yet", {31'd0, overrun}, 32'd0);
        for (int t = 0; t < 600 && sample != 16'h5678; t++) step();
        check("bp_second_sample", {16'd0, sample}, 32'h5678);
        check("bp_overrun_set", {31'd0, overrun}, 32'd1);
        check("bp_valid_held", {31'd0, valid}, 32'd1);
        ready = 1'b1;
        step();
        check("bp_valid_drop", {31'd0, valid}, 32'd0);
        check("bp_overrun_sticky", {31'd0, overrun}, 32'd1);
        enable = 1'b0;
        for (int t = 0; t < 1000 && busy; t++) step();
        check("bp_idle", {31'd0, busy}, 32'd0);
        check("bp_overrun_in_idle", {31'd0, overrun}, 32'd1);

        // Run 3: restart clears overrun, warm-up repeats, then async reset
        lw[2] = 32'hCAFE_0001; lw[3] = 32'h0F0F_0000;
        ready = 1'b0;
        start_run();
        step();
        check("restart_overrun_clear", {31'd0, overrun}, 32'd0);
        for (int t = 0; t < 1000 && !valid; t++) step();
        check("restart_latency", first_valid - en_cyc, FIRST_VALID);
        check("restart_sample", {16'd0, sample}, 32'hCAFE);
        for (int t = 0; t < 600 && !overrun; t++) step();
        check("restart_overrun", {31'd0, overrun}, 32'd1);
        #2;
        rst = 1'b1;
        enable = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (3) step();
        rst = 1'b0;
        quiet = 1'b1;
        for (int t = 0; t < 100; t++) begin
            step();
            if (sck || busy) quiet = 1'b0;
        end
        check("post_reset_quiet", {31'd0, quiet}, 32'd1);
        start_run();
        for (int t = 0; t < 20 && first_rise < 0; t++) step();
        check("rerun_first_rise", first_rise - en_cyc, CLK_DIV);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2s_rx_controller.md
# i2s_rx_controller

Master-side sequencer for the I2S microphone front end. Divides the system clock down to the I2S bit clock (`sck_out`) and word-select (`ws_out`), discards a configurable number of power-up frames, then deserializes the left-channel slot from the microphone into 16-bit signed samples. Samples are delivered to the downstream audio pipeline over a valid/ready handshake, with overrun detection.

## Interface
- `CLK_DIV`, default 16: `clk_in` cycles per `sck_out` half-period, ≥2. 98.304 MHz / 32 = 3.072 MHz.
- `WARMUP_FRAMES`, default 4096: full frames clocked out and discarded after enable, ≥1.
- `clk_in` input 1: system clock. One clock domain only.
- `rst_in` input 1: reset, asynchronous, active-high.
- `enable_in` input 1: level. Rising edge starts warm-up; low stops the block after the current frame.
- `mic_data_in` input 1: serial data from the microphone. Passes through a 2-flop synchronizer before use.
- `sck_out` output 1: I2S bit clock.
- `ws_out` output 1: word select. 0 = left slot, 1 = right slot.
- `sample_out` output 16: two's-complement sample, the top 16 bits of the left slot.
- `sample_valid_out` output 1: sample available. Held until accepted.
- `sample_ready_in` input 1: consumer accepts when `sample_valid_out && sample_ready_in`.
- `overrun_out` output 1: sticky. A new sample replaced an unaccepted one.
- `busy_out` output 1: state ≠ IDLE.

## Operation
- **States:** IDLE, WARMUP, RUN, DRAIN.
  - IDLE → WARMUP on a rising edge of `enable_in`.
  - WARMUP → RUN when the frame counter reaches `WARMUP_FRAMES` at a frame end.
  - WARMUP or RUN → DRAIN when `enable_in` is low.
  - DRAIN → IDLE at the next frame end.
  - Frame end: the `sck_out` falling edge where `bit_cnt` wraps 63→0.
- **Divider:** `div_cnt` runs 0..CLK_DIV-1 in every state except IDLE. At terminal count, `sck_out` toggles and `div_cnt` returns to 0.
- **Bit counter:** 6-bit `bit_cnt` increments on every `sck_out` falling edge and wraps 63→0.
  - `ws_out` is registered as `bit_cnt[5]` on the same falling edge.
  - A frame is 64 sck periods; 32-bit slots.
- **Capture:** on each `sck_out` rising edge in RUN with `bit_cnt` in 1..16, shift the synchronized `mic_data_in` into a 16-bit register, MSB first.
  - I2S one-bit delay: bit 0 of the slot is ignored.
  - Bits 17..63 are ignored, including the right slot.
  - Capture is not performed in WARMUP or DRAIN.
- **Delivery:** after the capture at `bit_cnt`==16, `sample_out` loads the shift register and `sample_valid_out` is set.
  - `sample_valid_out` clears on the cycle after handshake acceptance.
  - If a sample is still valid when the next one completes: the new sample overwrites it, valid stays high, and `overrun_out` is set.
  - `overrun_out` clears only on reset or on the IDLE→WARMUP transition.
- **In IDLE:**
  - `sck_out` and `ws_out` are held at 0.
  - Counters are cleared.
  - A pending sample remains valid until accepted.
- **Enable toggled during DRAIN:** the block completes DRAIN, enters IDLE, and requires a fresh rising edge of `enable_in` to restart.

## Timing
- **Reset values:**
  - `sck_out`=0, `ws_out`=0, `sample_out`=0, `sample_valid_out`=0, `overrun_out`=0, `busy_out`=0.
  - State IDLE, all counters 0, synchronizer 0.
  - Reset takes effect immediately, including mid-frame or mid-handshake.
- **Rates:**
  - sck period: 2·CLK_DIV `clk_in` cycles.
  - Frame: 128·CLK_DIV cycles.
  - Sample rate: `clk_in`/(128·CLK_DIV).
- **Start-up:** first `sck_out` rising edge occurs CLK_DIV cycles after the `clk_in` edge that registers the IDLE→WARMUP transition.
- **Sample latency:** `sample_valid_out` rises exactly 1 `clk_in` cycle after the `sck_out` rising edge that captures bit 16.
- **Synchronizer:** the data path sees `mic_data_in` 2 `clk_in` cycles late. This is safe for CLK_DIV ≥ 2, since data is stable for CLK_DIV cycles before the rising edge.
- **Ready:** may be tied high. Acceptance and a new sample on the same cycle deliver the new sample with no overrun.
- **Number of samples:** exactly (frames in RUN) samples. The frame completed in DRAIN yields none.

## Test plan
- **Reset:** assert `rst_in` mid-frame with CLK_DIV=2 → all outputs 0 within the same cycle; no `sck_out` activity until `enable_in` rises again.
- **Clock generation:** CLK_DIV=2, WARMUP_FRAMES=2, enable → `sck_out` period 4 cycles, `ws_out` low 128 cycles then high 128 cycles, and no `sample_valid_out` during the first 512 cycles.
- **Capture:** microphone model drives the left slot 0x8001_2300 and the right slot 0xFFFF_FFFF, with the I2S delay, `sample_ready_in`=1 → `sample_out`=0x8001, valid for 1 cycle, once per frame.
- **Backpressure:** hold `sample_ready_in`=0 for 2 frames with samples 0x1234 then 0x5678 → `sample_out`=0x5678, `overrun_out`=1; assert ready → valid drops next cycle, `overrun_out` stays 1 until re-enable.
- **Drain:** deassert `enable_in` at `bit_cnt`=10 of a RUN frame → the current frame completes, no sample is produced for it, and IDLE is reached at wrap with `busy_out`=0 and `sck_out`=`ws_out`=0.
- **Restart:** re-enable from IDLE → `overrun_out` cleared, warm-up repeats with WARMUP_FRAMES frames before the first valid sample.
